// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues one imem request at a time and
// hands each fetched word to decode over a valid/ready handshake, with redirect squash.
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] PC_STEP   = 16'd2,
  parameter logic [15:0] NOP_INSTR = 16'b0000100000000000,
  parameter logic [4:0]  HALT_OP   = 5'b00000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_done,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_inc,
  output logic        halted,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_SQUASH,
    S_HOLD,
    S_HALT
  } state_t;

  state_t      state;
  logic [15:0] pc;

  function automatic logic [15:0] pc_add(input logic [15:0] a);
    return a + PC_STEP;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      if_valid  <= 1'b0;
      if_instr  <= NOP_INSTR;
      if_pc     <= RESET_PC;
      if_pc_inc <= pc_add(RESET_PC);
      halted    <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          err       <= imem_done;
          imem_addr <= pc;
          imem_req  <= 1'b1;
          state     <= S_REQ;
        end
        S_REQ: begin
          if (imem_done) begin
            if (redirect) begin
              // Word belongs to the wrong path; restart at the target without dropping req.
              pc        <= redirect_pc;
              imem_addr <= redirect_pc;
            end else begin
              imem_req  <= 1'b0;
              if_valid  <= 1'b1;
              if_instr  <= imem_rdata;
              if_pc     <= imem_addr;
              if_pc_inc <= pc_add(imem_addr);
              pc        <= pc_add(imem_addr);
              state     <= S_HOLD;
            end
          end else if (redirect) begin
            pc    <= redirect_pc;
            state <= S_SQUASH;
          end
        end
        S_SQUASH: begin
          // The in-flight request must finish at its original address before retargeting.
          if (redirect) pc <= redirect_pc;
          if (imem_done) begin
            imem_addr <= redirect ? redirect_pc : pc;
            state     <= S_REQ;
          end
        end
        S_HOLD: begin
          err <= imem_done;
          if (redirect) begin
            if_valid  <= 1'b0;
            if_instr  <= NOP_INSTR;
            pc        <= redirect_pc;
            imem_addr <= redirect_pc;
            imem_req  <= 1'b1;
            state     <= S_REQ;
          end else if (id_ready) begin
            if_valid <= 1'b0;
            if_instr <= NOP_INSTR;
            if (if_instr[15:11] == HALT_OP) begin
              halted <= 1'b1;
              state  <= S_HALT;
            end else begin
              imem_addr <= pc;
              imem_req  <= 1'b1;
              state     <= S_REQ;
            end
          end
        end
        S_HALT: begin
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus randomized traffic against a
// transaction-level model of the expected fetch stream.
module tb_fetch_sequencer;
  localparam logic [15:0] RESET_PC  = 16'h0000;
  localparam logic [15:0] PC_STEP   = 16'd2;
  localparam logic [15:0] NOP_INSTR = 16'b0000100000000000;
  localparam logic [4:0]  HALT_OP   = 5'b00000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = 16'h0000;
  logic        imem_done = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        id_ready = 1'b0;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_inc;
  logic        halted;
  logic        err;

  fetch_sequencer #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP),
    .NOP_INSTR(NOP_INSTR),
    .HALT_OP  (HALT_OP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_done  (imem_done),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .id_ready   (id_ready),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_pc_inc  (if_pc_inc),
    .halted     (halted),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // memory responder
  bit          busy = 1'b0;
  int          cnt = 0;
  int          min_lat = 0;
  int          max_lat = 0;
  bit          fix_en = 1'b0;
  logic [15:0] fix_word = 16'h0000;
  bit          halt_en = 1'b0;
  logic [15:0] halt_addr = 16'h0000;

  // reference model: expected fetch stream and handshake status
  logic [15:0] exp_pc = RESET_PC;
  bit          exp_req = 1'b0;
  bit          exp_valid = 1'b0;
  bit          exp_halt = 1'b0;
  bit          exp_err = 1'b0;
  bit          m_idle = 1'b1;
  bit          stale = 1'b0;

  function automatic logic [15:0] memword(input logic [15:0] a);
    logic [15:0] w;
    if (halt_en && a == halt_addr) return 16'h0000;
    if (fix_en) return fix_word;
    w = a * 16'h9E37 + 16'h1234;
    if (w[15:11] == HALT_OP) w[15] = 1'b1;
    return w;
  endfunction

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    imem_done = 1'b0;
    redirect = 1'b0;
    id_ready = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    busy = 1'b0;
    exp_pc = RESET_PC;
    exp_req = 1'b0;
    exp_valid = 1'b0;
    exp_halt = 1'b0;
    stale = 1'b0;
    m_idle = 1'b1;
    chk1("rst_req", imem_req, 1'b0);
    chk16("rst_addr", imem_addr, RESET_PC);
    chk1("rst_valid", if_valid, 1'b0);
    chk16("rst_instr", if_instr, NOP_INSTR);
    chk16("rst_pc", if_pc, RESET_PC);
    chk16("rst_pc_inc", if_pc_inc, RESET_PC + PC_STEP);
    chk1("rst_halted", halted, 1'b0);
    chk1("rst_err", err, 1'b0);
  endtask

  // One clock: called at a negedge, drives inputs, advances the model, checks at next negedge.
  task automatic step(input bit rdir, input logic [15:0] rpc, input bit rdy, input bit stray);
    bit          done;
    bit          accept;
    bit          halt_acc;
    bit          n_req;
    bit          n_valid;
    bit          req_before;
    logic [15:0] addr_before;
    logic [15:0] w;
    done = 1'b0;
    if (imem_req && !busy) begin
      busy = 1'b1;
      cnt = int'($urandom_range(max_lat, min_lat));
    end
    if (busy) begin
      if (cnt == 0) begin
        done = 1'b1;
        busy = 1'b0;
      end else begin
        cnt--;
      end
    end
    if (stray && !imem_req) done = 1'b1;
    imem_done = done;
    imem_rdata = done ? memword(imem_addr) : 16'($urandom);
    redirect = rdir;
    redirect_pc = rpc;
    id_ready = rdy;
    addr_before = imem_addr;
    req_before = imem_req;

    exp_err = done && !exp_req && !exp_halt;
    accept = exp_valid && rdy && !rdir;
    w = memword(exp_pc);
    halt_acc = accept && (w[15:11] == HALT_OP);
    if (exp_req && done && !stale) chk16("req_addr", imem_addr, exp_pc);
    n_req = m_idle || (exp_req && !(done && !rdir && !stale)) ||
            (exp_valid && (rdir || (rdy && !halt_acc)));
    n_valid = (exp_req && done && !rdir && !stale) || (exp_valid && !rdy && !rdir);
    if (exp_req && done) stale = 1'b0;
    else if (exp_req && rdir) stale = 1'b1;
    if (rdir && (exp_req || exp_valid) && !exp_halt) exp_pc = rpc;
    else if (accept) exp_pc = exp_pc + PC_STEP;
    exp_halt = exp_halt || halt_acc;
    exp_req = n_req;
    exp_valid = n_valid;
    m_idle = 1'b0;

    @(posedge clk);
    @(negedge clk);
    chk1("imem_req", imem_req, exp_req);
    chk1("if_valid", if_valid, exp_valid);
    chk1("halted", halted, exp_halt);
    chk1("err", err, exp_err);
    if (req_before && !done && exp_req) chk16("addr_stable", imem_addr, addr_before);
    if (exp_valid) begin
      chk16("if_pc", if_pc, exp_pc);
      chk16("if_instr", if_instr, memword(exp_pc));
      chk16("if_pc_inc", if_pc_inc, exp_pc + PC_STEP);
    end else begin
      chk16("if_instr_nop", if_instr, NOP_INSTR);
    end
  endtask

  task automatic wait_valid(input int limit);
    for (int i = 0; i < limit && !exp_valid; i++) step(1'b0, 16'h0000, 1'b0, 1'b0);
    chk1("wait_valid", if_valid, 1'b1);
  endtask

  initial begin
    // single-cycle memory, sequential stream
    do_reset(2);
    fix_en = 1'b1;
    fix_word = 16'hD800;
    min_lat = 0;
    max_lat = 0;
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    chk16("t1_addr0", imem_addr, 16'h0000);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    chk16("t1_instr", if_instr, 16'hD800);
    chk16("t1_pc_inc", if_pc_inc, 16'h0002);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    chk16("t1_addr1", imem_addr, 16'h0002);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    chk16("t1_addr2", imem_addr, 16'h0004);
    fix_en = 1'b0;

    // redirect while a slow request is outstanding
    do_reset(1);
    min_lat = 3;
    max_lat = 3;
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b1, 16'h3232, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    chk16("t2_addr", imem_addr, 16'h3232);
    wait_valid(20);
    chk16("t2_if_pc", if_pc, 16'h3232);

    // decode stalls, then redirect wins over ready
    repeat (4) step(1'b0, 16'h0000, 1'b0, 1'b0);
    chk1("t3_held", if_valid, 1'b1);
    step(1'b1, 16'h0A0A, 1'b1, 1'b0);
    chk1("t3_dropped", if_valid, 1'b0);
    chk16("t3_addr", imem_addr, 16'h0A0A);

    // PC wrap-around
    min_lat = 0;
    max_lat = 0;
    wait_valid(20);
    step(1'b1, 16'hFFFE, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    chk16("t5_if_pc", if_pc, 16'hFFFE);
    chk16("t5_pc_inc", if_pc_inc, 16'h0000);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    chk16("t5_addr", imem_addr, 16'h0000);

    // HALT word stops fetch until reset
    halt_en = 1'b1;
    halt_addr = 16'h0100;
    wait_valid(20);
    step(1'b1, 16'h0100, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    chk16("t4_halt_word", if_instr, 16'h0000);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    chk1("t4_halted", halted, 1'b1);
    for (int i = 0; i < 10; i++)
      step(1'($urandom_range(0, 1)), 16'($urandom) & 16'hFFFE, 1'b1, 1'b0);
    chk1("t4_no_req", imem_req, 1'b0);
    halt_en = 1'b0;
    do_reset(2);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    chk16("t4_resume", imem_addr, RESET_PC);
    chk1("t4_resume_req", imem_req, 1'b1);

    // reset during squash, then a stray completion
    min_lat = 3;
    max_lat = 3;
    do_reset(1);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b1, 16'h4444, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    do_reset(1);
    step(1'b0, 16'h0000, 1'b1, 1'b1);
    chk1("t6_err", err, 1'b1);
    chk16("t6_addr", imem_addr, RESET_PC);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    chk1("t6_err_pulse", err, 1'b0);

    // randomized traffic
    min_lat = 0;
    max_lat = 3;
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) do_reset(1);
      step($urandom_range(0, 5) == 0, 16'($urandom) & 16'hFFFE,
           $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
